// File: rtl/hive_reg_uart_rx.sv
// Receive half of the rbus UART. It oversamples the line with a phase-accumulator
// tick, frames LSB-first data bytes, and queues them in a FIFO that rbus reads pop.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_BRK   | line held low (break or reset mid-frame); wait for it to go high
//   S_IDLE  | line high; wait for the falling edge of a start bit
//   S_START | count to the middle of the start bit and confirm it is still low
//   S_DATA  | sample the data bits at mid-bit, LSB first
//   S_STOP  | sample the stop bit; high pushes the byte, low flags a framing error
module hive_reg_uart_rx #(
  parameter int ALU_W       = 32,
  parameter int RBUS_ADDR_W = 4,
  parameter int ADDR        = 5,
  parameter int DATA_W      = 8,
  parameter int CLK_HZ      = 160000000,
  parameter int BAUD_HZ     = 115200,
  parameter int OSR         = 16,
  parameter int FIFO_ADDR_W = 4,
  parameter int SYNC_W      = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
  input  logic                   rbus_wr_i,
  input  logic                   rbus_rd_i,
  input  logic [ALU_W-1:0]       rbus_wr_data_i,
  output logic [ALU_W-1:0]       rbus_rd_data_o,
  input  logic                   uart_rx_i,
  output logic                   rx_rdy_o
);

  localparam logic [63:0] INC_64 =
    ((64'(BAUD_HZ) * 64'(OSR) * (64'd1 << 32)) + (64'(CLK_HZ) / 64'd2)) / 64'(CLK_HZ);
  localparam logic [31:0] INC   = INC_64[31:0];
  localparam int          CNT_W = $clog2(OSR);
  localparam int          BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int          DEPTH = 2 ** FIFO_ADDR_W;

  typedef enum logic [2:0] {S_BRK, S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [31:0]            acc;
  logic [32:0]            acc_sum;
  logic                   tick;
  logic [SYNC_W-1:0]      sync;
  logic                   line;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_W-1:0]       bit_idx;
  logic [DATA_W-1:0]      shreg;
  logic                   sample;
  logic                   push;
  logic                   frm_set;

  logic [DATA_W-1:0]      mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr;
  logic [FIFO_ADDR_W-1:0] rd_ptr;
  logic [FIFO_ADDR_W:0]   count;
  logic [FIFO_ADDR_W:0]   count_nxt;
  logic                   empty;
  logic                   full;
  logic                   rd_hit;
  logic                   wr_hit;
  logic                   pop;
  logic                   push_ok;
  logic                   ovr_set;
  logic                   ovr;
  logic                   frm;
  logic [ALU_W-1:0]       rd_word;
  logic                   unused_wr_bits;

  assign acc_sum = {1'b0, acc} + {1'b0, INC};
  assign tick    = acc_sum[32];
  assign line    = sync[SYNC_W-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc  <= '0;
      sync <= '1;
    end else begin
      acc  <= acc_sum[31:0];
      sync <= {sync[SYNC_W-2:0], uart_rx_i};
    end
  end

  // Down-counters reload on every mid-bit sample; terminal count is zero.
  assign sample  = tick && (cnt == '0);
  assign push    = (state == S_STOP) && sample && line;
  assign frm_set = (state == S_STOP) && sample && !line;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_BRK;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_BRK: begin
          if (line) state <= S_IDLE;
        end
        S_IDLE: begin
          if (!line) begin
            state <= S_START;
            cnt   <= CNT_W'(OSR / 2 - 1);
          end
        end
        S_START: begin
          if (tick) begin
            if (cnt == '0) begin
              if (!line) begin
                state   <= S_DATA;
                cnt     <= CNT_W'(OSR - 1);
                bit_idx <= '0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (cnt == '0) begin
              shreg[bit_idx] <= line;
              cnt            <= CNT_W'(OSR - 1);
              if (bit_idx == BIT_W'(DATA_W - 1)) state <= S_STOP;
              else bit_idx <= bit_idx + 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (cnt == '0) state <= line ? S_IDLE : S_BRK;
            else cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_BRK;
      endcase
    end
  end

  assign rd_hit  = rbus_rd_i && (rbus_addr_i == RBUS_ADDR_W'(ADDR));
  assign wr_hit  = rbus_wr_i && (rbus_addr_i == RBUS_ADDR_W'(ADDR));
  assign empty   = (count == '0);
  assign full    = (count == (FIFO_ADDR_W + 1)'(DEPTH));
  assign pop     = rd_hit && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    rd_word          = '0;
    rd_word[ALU_W-1] = empty;
    rd_word[ALU_W-2] = ovr;
    rd_word[ALU_W-3] = frm;
    if (!empty) rd_word[DATA_W-1:0] = mem[rd_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      ovr            <= 1'b0;
      frm            <= 1'b0;
      rx_rdy_o       <= 1'b0;
      rbus_rd_data_o <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count          <= count_nxt;
      rx_rdy_o       <= (count_nxt != '0);
      rbus_rd_data_o <= rd_hit ? rd_word : '0;
      if (ovr_set)                               ovr <= 1'b1;
      else if (wr_hit && rbus_wr_data_i[ALU_W-2]) ovr <= 1'b0;
      if (frm_set)                               frm <= 1'b1;
      else if (wr_hit && rbus_wr_data_i[ALU_W-3]) frm <= 1'b0;
    end
  end

  assign unused_wr_bits = ^{rbus_wr_data_i[ALU_W-1], rbus_wr_data_i[ALU_W-4:0]};

endmodule

// File: tb/tb_hive_reg_uart_rx.sv
// Bench for hive_reg_uart_rx: drives serial frames and rbus accesses, and checks
// every read against a queue-based model of the receive FIFO and error flags.
module tb_hive_reg_uart_rx;

  localparam int ALU_W       = 32;
  localparam int RBUS_ADDR_W = 4;
  localparam int ADDR        = 5;
  localparam int DATA_W      = 8;
  localparam int CLK_HZ      = 3686400;
  localparam int BAUD_HZ     = 115200;
  localparam int OSR         = 16;
  localparam int FIFO_ADDR_W = 2;
  localparam int SYNC_W      = 2;
  localparam int BIT_CLKS    = CLK_HZ / BAUD_HZ;
  localparam int DEPTH       = 2 ** FIFO_ADDR_W;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [RBUS_ADDR_W-1:0] rbus_addr_i;
  logic                   rbus_wr_i;
  logic                   rbus_rd_i;
  logic [ALU_W-1:0]       rbus_wr_data_i;
  logic [ALU_W-1:0]       rbus_rd_data_o;
  logic                   uart_rx_i;
  logic                   rx_rdy_o;

  hive_reg_uart_rx #(
    .ALU_W(ALU_W), .RBUS_ADDR_W(RBUS_ADDR_W), .ADDR(ADDR), .DATA_W(DATA_W),
    .CLK_HZ(CLK_HZ), .BAUD_HZ(BAUD_HZ), .OSR(OSR), .FIFO_ADDR_W(FIFO_ADDR_W),
    .SYNC_W(SYNC_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rbus_addr_i(rbus_addr_i), .rbus_wr_i(rbus_wr_i),
    .rbus_rd_i(rbus_rd_i), .rbus_wr_data_i(rbus_wr_data_i),
    .rbus_rd_data_o(rbus_rd_data_o), .uart_rx_i(uart_rx_i), .rx_rdy_o(rx_rdy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] mq[$];
  bit         m_ovr = 1'b0;
  bit         m_frm = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop);
    if (stop) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovr = 1'b1;
    end else begin
      m_frm = 1'b1;
    end
  endtask

  task automatic model_read(output logic [31:0] w);
    w     = '0;
    w[31] = (mq.size() == 0);
    w[30] = m_ovr;
    w[29] = m_frm;
    if (mq.size() != 0) w[7:0] = mq.pop_front();
  endtask

  task automatic model_write(input logic [31:0] d);
    if (d[30]) m_ovr = 1'b0;
    if (d[29]) m_frm = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic do_read(output logic [31:0] w);
    @(posedge clk_i); #1;
    rbus_addr_i = RBUS_ADDR_W'(ADDR);
    rbus_rd_i   = 1'b1;
    @(posedge clk_i); #1;
    rbus_rd_i = 1'b0;
    w = rbus_rd_data_o;
  endtask

  task automatic do_write(input logic [31:0] d);
    @(posedge clk_i); #1;
    rbus_addr_i    = RBUS_ADDR_W'(ADDR);
    rbus_wr_data_i = d;
    rbus_wr_i      = 1'b1;
    @(posedge clk_i); #1;
    rbus_wr_i = 1'b0;
  endtask

  task automatic read_check(input string tag);
    logic [31:0] w;
    logic [31:0] e;
    do_read(w);
    model_read(e);
    check(tag, w, e);
  endtask

  // One 10-bit frame, started on an even cycle so the tick phase repeats between
  // frames. rd_at/rst_at pulse rbus_rd_i/rst_i at that clock offset (negative = none).
  task automatic send_frame(input logic [7:0] d, input bit stop, input int rd_at,
                            input int rst_at, output int lat, output logic [31:0] cap,
                            output logic rdy_cap);
    logic [9:0] bits;
    bits    = {stop, d, 1'b0};
    lat     = -1;
    cap     = 'x;
    rdy_cap = 1'bx;
    do begin @(posedge clk_i); #1; end while (cyc % 2 != 0);
    for (int i = 0; i < 10 * BIT_CLKS; i++) begin
      if (i != 0) begin @(posedge clk_i); #1; end
      if (lat < 0 && rx_rdy_o) lat = i;
      if (rd_at >= 0 && i == rd_at + 1) cap = rbus_rd_data_o;
      if (rst_at >= 0 && i == rst_at + 1) rdy_cap = rx_rdy_o;
      uart_rx_i   = bits[i / BIT_CLKS];
      rbus_addr_i = RBUS_ADDR_W'(ADDR);
      rbus_rd_i   = (rd_at >= 0 && i == rd_at);
      rst_i       = (rst_at >= 0 && (i == rst_at || i == rst_at + 1));
    end
    @(posedge clk_i); #1;
    rbus_rd_i = 1'b0;
    rst_i     = 1'b0;
  endtask

  initial begin
    int          lat;
    int          lat_ref;
    logic [31:0] cap;
    logic [31:0] e;
    logic        rdyc;
    logic [7:0]  b;

    rst_i = 1'b1; uart_rx_i = 1'b1; rbus_rd_i = 1'b0; rbus_wr_i = 1'b0;
    rbus_addr_i = '0; rbus_wr_data_i = '0;
    idle(3);
    check("reset_rd_data", rbus_rd_data_o, 32'h0);
    check("reset_rx_rdy", 32'(rx_rdy_o), 32'h0);
    rst_i = 1'b0;
    idle(20);
    read_check("reset_read_empty");

    // single good frame and its arrival latency
    send_frame(8'hA5, 1'b1, -1, -1, lat, cap, rdyc);
    model_frame(8'hA5, 1'b1);
    uart_rx_i = 1'b1;
    check("a5_latency_window", 32'(lat >= 300 && lat <= 316), 32'h1);
    check("a5_rx_rdy", 32'(rx_rdy_o), 32'h1);
    read_check("a5_read");
    check("a5_rx_rdy_clear", 32'(rx_rdy_o), 32'h0);
    read_check("a5_read_empty");

    // short low glitch must not start a frame
    @(posedge clk_i); #1 uart_rx_i = 1'b0;
    idle(13);
    uart_rx_i = 1'b1;
    idle(400);
    check("glitch_rx_rdy", 32'(rx_rdy_o), 32'h0);
    read_check("glitch_read");

    // framing error, then line stuck low for three bit times
    send_frame(8'h3C, 1'b0, -1, -1, lat, cap, rdyc);
    model_frame(8'h3C, 1'b0);
    idle(3 * BIT_CLKS);
    uart_rx_i = 1'b1;
    idle(40);
    check("frm_rx_rdy", 32'(rx_rdy_o), 32'h0);
    read_check("frm_read");
    do_write(32'h2000_0000);
    model_write(32'h2000_0000);
    read_check("frm_cleared");

    // overrun: six frames into a four-entry FIFO
    for (int k = 1; k <= 6; k++) begin
      send_frame(8'(k), 1'b1, -1, -1, lat, cap, rdyc);
      model_frame(8'(k), 1'b1);
      idle(8);
    end
    check("ovr_rx_rdy", 32'(rx_rdy_o), 32'h1);
    for (int k = 0; k < 5; k++) read_check("ovr_read");
    do_write(32'h4000_0000);
    model_write(32'h4000_0000);
    read_check("ovr_cleared");

    // random payloads with random gaps
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, -1, -1, lat, cap, rdyc);
      model_frame(b, 1'b1);
      idle($urandom_range(2, 40));
    end
    for (int k = 0; k < 4; k++) read_check("rand_read");

    // reset in the middle of bit 3 drops the buffered byte and the partial frame
    send_frame(8'h77, 1'b1, -1, -1, lat, cap, rdyc);
    model_frame(8'h77, 1'b1);
    idle(8);
    send_frame(8'hF8, 1'b1, 4 * BIT_CLKS + 16, 4 * BIT_CLKS + 16, lat, cap, rdyc);
    mq.delete();
    m_ovr = 1'b0;
    m_frm = 1'b0;
    check("rst_mid_rd_data", cap, 32'h0);
    check("rst_mid_rx_rdy", 32'(rdyc), 32'h0);
    idle(40);
    read_check("rst_mid_fifo_empty");
    send_frame(8'h55, 1'b1, -1, -1, lat, cap, rdyc);
    model_frame(8'h55, 1'b1);
    idle(8);
    read_check("rst_then_55");
    read_check("rst_then_empty");

    // pop aligned with the push of a fifth frame into a full FIFO
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, -1, -1, lat_ref, cap, rdyc);
    model_frame(b, 1'b1);
    idle(8);
    check("coinc_latency_window", 32'(lat_ref >= 300 && lat_ref <= 316), 32'h1);
    read_check("coinc_ref_read");
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, -1, -1, lat, cap, rdyc);
      model_frame(b, 1'b1);
      idle(8);
    end
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, lat_ref - 1, -1, lat, cap, rdyc);
    model_read(e);
    model_frame(b, 1'b1);
    check("coinc_pop_data", cap, e);
    idle(8);
    for (int k = 0; k < DEPTH; k++) read_check("coinc_drain");
    read_check("coinc_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hive_reg_uart_rx.md
Name: hive_reg_uart_rx

Overview:
- RX half of the DATA_W,n,1 RS232 UART on the hive register bus (rbus).
- Synchronizes the serial line and oversamples it with a phase-accumulator tick generator.
- Frames bytes LSB first, validates start and stop bits, and buffers received bytes in an internal FIFO.
- Core reads one rbus register to pop data and read status flags, and writes it to clear sticky errors; rx_rdy_o serves as an interrupt/poll source.

Parameters:
- ALU_W, 32: rbus data width.
- RBUS_ADDR_W, 4: rbus address width.
- ADDR, 5: rbus address decoded by this block.
- DATA_W, 8: UART data bits per frame, 5..9.
- CLK_HZ, 160000000: core clock frequency.
- BAUD_HZ, 115200: line rate.
- OSR, 16: oversample ticks per bit; power of 2, >=8.
- FIFO_ADDR_W, 4: FIFO depth is 2^FIFO_ADDR_W entries.
- SYNC_W, 2: synchronizer flop count on uart_rx_i, >=2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active high.
- rbus_addr_i  in  RBUS_ADDR_W  address.
- rbus_wr_i  in  1  write enable, active high.
- rbus_rd_i  in  1  read enable, active high.
- rbus_wr_data_i  in  ALU_W  write data.
- rbus_rd_data_o  out  ALU_W  read data.
- uart_rx_i  in  1  serial data, async, idles high.
- rx_rdy_o  out  1  FIFO not empty.

Behaviour:
- Reset (synchronous, rst_i high at a clk_i edge):
  - rbus_rd_data_o=0, rx_rdy_o=0.
  - FIFO emptied; ovr and frm flags cleared; accumulator cleared.
  - Synchronizer flops set to 1; FSM goes to BRK.
- Tick generator:
  - 32-bit accumulator; INC = round(BAUD_HZ*OSR*2^32/CLK_HZ).
  - tick = carry out of acc+INC.
  - Free-running, never reset except by rst_i.
- FSM (acts only on tick cycles, except the BRK/IDLE line tests below):
  - BRK: wait for synced line = 1, then IDLE.
  - IDLE: synced line = 0 -> START, tick counter cnt=0.
  - START: on tick, cnt++. At cnt=OSR/2-1, sample: line 0 -> DATA with cnt=0, bit=0; line 1 -> IDLE (glitch, nothing recorded).
  - DATA: on tick, cnt++. At cnt=OSR-1, sample into shift register at position bit (LSB first) and reset cnt. After bit DATA_W-1 -> STOP.
  - STOP: at cnt=OSR-1, sample.
    - Line 1: push the byte, then IDLE.
    - Line 0: set frm, discard the byte, go to BRK.
- FIFO push:
  - Push occurs in the cycle the stop bit samples 1.
  - If FIFO is full and no pop happens in the same cycle: byte dropped, ovr set.
  - Full with a simultaneous pop: push accepted, count unchanged.
- rbus read (rbus_rd_i=1 and rbus_addr_i==ADDR):
  - rbus_rd_data_o registered, valid the cycle after the request, 0 on all other cycles.
  - Bit ALU_W-1 = FIFO empty.
  - Bit ALU_W-2 = ovr.
  - Bit ALU_W-3 = frm.
  - Bits DATA_W-1:0 = FIFO head; all other bits 0.
  - If not empty, the head is popped at the request edge.
  - Reading an empty FIFO returns data bits 0 with empty=1; FIFO state unchanged.
- rbus write (rbus_wr_i=1 and rbus_addr_i==ADDR):
  - wr_data bit ALU_W-2 = 1 clears ovr; bit ALU_W-3 = 1 clears frm. Other bits ignored.
  - If a flag is cleared and set in the same cycle, set wins.
- Read and write in the same cycle: both take effect. The returned flags are the pre-edge values.
- Pointers wrap modulo 2^FIFO_ADDR_W; a count of FIFO_ADDR_W+1 bits distinguishes full from empty.
- rx_rdy_o is registered and equals count!=0 after each edge.
- Timing: a byte becomes visible on rx_rdy_o 1 cycle after the mid-stop-bit sample.
- rst_i mid-frame aborts the partial byte. Reception resumes only after the line returns high (BRK).

Test Plan (bench config CLK_HZ=3686400, BAUD_HZ=115200, OSR=16 -> INC=2^31, 32 clocks/bit; DATA_W=8, FIFO_ADDR_W=2):
- Single frame 0xA5 with stop=1 -> rx_rdy_o rises about 312 clocks after the falling start edge. Read returns 0x000000A5; the next read returns 0x80000000.
- 0.4-bit (13-clock) low glitch on an idle line -> FSM back in IDLE, no push, rx_rdy_o stays 0, flags 0.
- Frame 0x3C with stop bit 0, then line held low for 3 bits -> frm=1. Read returns 0xA0000000 and the FIFO stays empty. Write 0x20000000 -> next read 0x80000000.
- Six frames 0x01..0x06 with no reads -> FIFO holds 0x01..0x04 and ovr=1. Reads return 0x40000001..0x40000004, then 0xC0000000.
- rst_i pulse during bit 3 of a frame -> rbus_rd_data_o=0 and rx_rdy_o=0. Remaining bits are ignored until the line is high, and the next clean frame 0x55 is received correctly.
- Read pop coinciding with a push while the FIFO is full -> no overrun, ordering preserved, count stays 4.
